uart_16550_tx_fifo: RTL and testbench
=====================================

UART_16550_TX_FIFO -- requirements
Module: uart_16550_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning log2 of FIFO depth (16 entries); level width L = DEPTH_LOG2+1.
REQ-002 SHALL have port WBs_CLK_i  input  1  Wishbone fabric clock; all state on rising edge.
REQ-003 SHALL have port WBs_RST_i  input  1  Wishbone fabric reset, asynchronous, active-high.
REQ-004 SHALL have port Tx_FIFO_Enable_i  input  1  1 = FIFO mode (capacity 2^DEPTH_LOG2); 0 = holding-register mode (capacity 1).
REQ-005 SHALL have port Tx_FIFO_Flush_i  input  1  synchronous flush request (FCR Tx clear).
REQ-006 SHALL have port Tx_FIFO_Push_i  input  1  one-cycle write strobe from THR write.
REQ-007 SHALL have port Tx_FIFO_DAT_i  input  8  byte to push.
REQ-008 SHALL have port Tx_FIFO_Pop_i  input  1  one-cycle strobe from transmitter shift-register load.
REQ-009 SHALL have port Tx_FIFO_DAT_o  output  8  head-of-FIFO byte, first-word fall-through.
REQ-010 SHALL have port Tx_FIFO_Level_o  output  L  registered entry count.
REQ-011 SHALL have port Tx_FIFO_Empty_o  output  1  registered, 1 when level = 0 (THRE source).
REQ-012 SHALL have port Tx_FIFO_Full_o  output  1  registered, 1 when level = current capacity.
REQ-013 SHALL have port Tx_FIFO_Overflow_o  output  1  registered one-cycle pulse for a rejected push.

Function
REQ-014 SHALL store data in an internal 2^DEPTH_LOG2 x 8 array addressed by DEPTH_LOG2-bit write and read pointers that wrap modulo depth.
REQ-015 SHALL accept a push when Push_i=1 and (Full_o=0 or Pop_i accepted the same cycle): write DAT_i at write pointer, increment write pointer.
REQ-016 SHALL accept a pop when Pop_i=1 and Empty_o=0: increment read pointer; pop while empty is ignored, no state change.
REQ-017 SHALL update level: push only +1; pop only -1; both accepted hold; neither hold.
REQ-018 Simultaneous push+pop when empty: push accepted, pop ignored, level 0->1.
REQ-019 Simultaneous push+pop when full: both accepted, level holds at capacity, outgoing byte is the pre-edge head.
REQ-020 SHALL assert Overflow_o for exactly the cycle after a push rejected because full; stored data, pointers, level unchanged.
REQ-021 SHALL drive DAT_o = array[read pointer] combinationally when Empty_o=0, else 8'h00.
REQ-022 Empty_o and Full_o SHALL be registered and reflect the post-edge level in the same cycle Level_o updates (no extra latency).
REQ-023 Capacity SHALL be 1 when Enable_i=0; holding mode shares the same array and pointers.
REQ-024 SHALL register Enable_i into Enable_q; a cycle where Enable_i != Enable_q SHALL act as a flush.
REQ-025 Flush (Flush_i=1 or enable change) SHALL next-edge set pointers 0, level 0, Empty_o 1, Full_o 0, Overflow_o 0, and ignore same-cycle push/pop; flush takes priority over all other operations.
REQ-026 Array contents SHALL NOT be cleared by flush or reset; they are unobservable because DAT_o is forced to 0 while empty.

Reset
REQ-027 WBs_RST_i=1 SHALL immediately force pointers 0, Level_o 0, Empty_o 1, Full_o 0, Overflow_o 0, Enable_q 0, independent of clock.
REQ-028 If Enable_i=1 at reset release, the first edge SHALL perform a (harmless) enable-change flush.
REQ-029 Reset asserted mid-operation SHALL discard all queued bytes; the first push after release SHALL appear on DAT_o the next cycle.

Verification
REQ-030 FIFO mode: push 0x41,0x42,0x43 -> Level 3, DAT_o 0x41, Empty 0; one pop -> DAT_o 0x42, Level 2.
REQ-031 Push 0x00..0x0F -> Full 1 after 16th edge, Level 16; push 0xAA -> Overflow 1 for one cycle, Level 16; 16 pops return 0x00..0x0F in order, Empty 1 after last.
REQ-032 Wrap: push/pop 10 bytes, then push 16 bytes 0x10..0x1F -> Full 1; pops return 0x10..0x1F in order across pointer wrap.
REQ-033 Push+pop same cycle at level 0 (-> Level 1, DAT_o new byte), level 5 (-> Level 5, head advances), level 16 (-> Level 16, no Overflow).
REQ-034 Holding mode (Enable_i=0): push 0x55 -> Level 1, Full 1, DAT_o 0x55; push 0x66 -> Overflow pulse, DAT_o 0x55; pop -> Empty 1, DAT_o 0x00.
REQ-035 At Level 7: Flush_i pulse with push -> Level 0, Empty 1, push dropped; toggle Enable_i at Level 3 -> Level 0 next edge; async reset mid-burst -> Level 0, Empty 1 without clock edge.

Source files
------------

// File: rtl/uart_16550_tx_fifo_if.sv
// Transmit-FIFO port bundle between the 16550 register block (master)
// and the Tx FIFO (slave).
interface uart_16550_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  Tx_FIFO_Enable_i;
    logic                  Tx_FIFO_Flush_i;
    logic                  Tx_FIFO_Push_i;
    logic [7:0]            Tx_FIFO_DAT_i;
    logic                  Tx_FIFO_Pop_i;
    logic [7:0]            Tx_FIFO_DAT_o;
    logic [DEPTH_LOG2:0]   Tx_FIFO_Level_o;
    logic                  Tx_FIFO_Empty_o;
    logic                  Tx_FIFO_Full_o;
    logic                  Tx_FIFO_Overflow_o;

    modport master (
        output Tx_FIFO_Enable_i, Tx_FIFO_Flush_i, Tx_FIFO_Push_i, Tx_FIFO_DAT_i, Tx_FIFO_Pop_i,
        input  Tx_FIFO_DAT_o, Tx_FIFO_Level_o, Tx_FIFO_Empty_o, Tx_FIFO_Full_o, Tx_FIFO_Overflow_o
    );
    modport slave (
        input  Tx_FIFO_Enable_i, Tx_FIFO_Flush_i, Tx_FIFO_Push_i, Tx_FIFO_DAT_i, Tx_FIFO_Pop_i,
        output Tx_FIFO_DAT_o, Tx_FIFO_Level_o, Tx_FIFO_Empty_o, Tx_FIFO_Full_o, Tx_FIFO_Overflow_o
    );
endinterface

// File: rtl/uart_16550_tx_fifo.sv
// 16550 transmit FIFO: first-word fall-through, FIFO or single holding-register
// capacity, registered level/empty/full flags and one-cycle overflow pulse.
module uart_16550_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    uart_16550_tx_fifo_if.slave  fifo_if
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CAP_FIFO = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CAP_HOLD = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_empty, r_full, r_ovf, r_enable_q;

    logic                  w_flush, w_push_ok, w_pop_ok, w_ovf;
    logic [DEPTH_LOG2:0]   w_cap, w_level_nxt;
    logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

    // A mode change re-sizes the queue, so it is treated exactly like a flush.
    assign w_flush   = fifo_if.Tx_FIFO_Flush_i | (fifo_if.Tx_FIFO_Enable_i != r_enable_q);
    assign w_pop_ok  = fifo_if.Tx_FIFO_Pop_i & ~r_empty;
    assign w_push_ok = fifo_if.Tx_FIFO_Push_i & (~r_full | w_pop_ok);
    assign w_ovf     = fifo_if.Tx_FIFO_Push_i & r_full & ~w_pop_ok;
    assign w_cap     = fifo_if.Tx_FIFO_Enable_i ? CAP_FIFO : CAP_HOLD;

    always_comb begin
        w_level_nxt  = r_level;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_flush) begin
            w_level_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push_ok) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            if (w_pop_ok)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      w_level_nxt = r_level + 1'b1;
            else if (w_pop_ok && !w_push_ok) w_level_nxt = r_level - 1'b1;
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_enable_q <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == w_cap);
            r_ovf      <= w_ovf & ~w_flush;
            r_enable_q <= fifo_if.Tx_FIFO_Enable_i;
        end
    end

    // Storage is never cleared; stale bytes are hidden by the empty gate on DAT_o.
    always_ff @(posedge WBs_CLK_i) begin
        if (w_push_ok && !w_flush) r_mem[r_wr_ptr] <= fifo_if.Tx_FIFO_DAT_i;
    end

    assign fifo_if.Tx_FIFO_DAT_o      = r_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign fifo_if.Tx_FIFO_Level_o    = r_level;
    assign fifo_if.Tx_FIFO_Empty_o    = r_empty;
    assign fifo_if.Tx_FIFO_Full_o     = r_full;
    assign fifo_if.Tx_FIFO_Overflow_o = r_ovf;
endmodule

// File: tb/tb_uart_16550_tx_fifo.sv
// Directed bench for uart_16550_tx_fifo: vector table plus hand-written
// full/overflow/wrap/flush/holding/reset sequences.
module tb_uart_16550_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    uart_16550_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_16550_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .WBs_CLK_i (clk),
        .WBs_RST_i (rst),
        .fifo_if   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, flush, en;
        logic [7:0] din;
        logic [4:0] lvl;
        logic       emp, ful, ovf;
        logic [7:0] dat;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [4:0] lvl, input logic emp, ful, ovf,
                       input logic [7:0] dat);
        logic [15:0] got, exp;
        got = {bus.Tx_FIFO_Level_o, bus.Tx_FIFO_Empty_o, bus.Tx_FIFO_Full_o,
               bus.Tx_FIFO_Overflow_o, bus.Tx_FIFO_DAT_o};
        exp = {lvl, emp, ful, ovf, dat};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got lvl=%0d emp=%b ful=%b ovf=%b dat=%h, want lvl=%0d emp=%b ful=%b ovf=%b dat=%h",
                     nm, got[15:11], got[10], got[9], got[8], got[7:0],
                     lvl, emp, ful, ovf, dat);
        end
    endtask

    // Drive one cycle's inputs at negedge, then sample 1 ns after the rising edge.
    task automatic step(input logic push, pop, flush, en, input logic [7:0] din);
        @(negedge clk);
        bus.Tx_FIFO_Push_i   = push;
        bus.Tx_FIFO_Pop_i    = pop;
        bus.Tx_FIFO_Flush_i  = flush;
        bus.Tx_FIFO_Enable_i = en;
        bus.Tx_FIFO_DAT_i    = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          push pop fl en din     lvl emp ful ovf dat
        vt[0]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 5'd0,1'b1,1'b0,1'b0,8'h00}; // enable-change flush
        vt[1]  = '{1'b1,1'b0,1'b0,1'b1,8'h41, 5'd1,1'b0,1'b0,1'b0,8'h41};
        vt[2]  = '{1'b1,1'b0,1'b0,1'b1,8'h42, 5'd2,1'b0,1'b0,1'b0,8'h41};
        vt[3]  = '{1'b1,1'b0,1'b0,1'b1,8'h43, 5'd3,1'b0,1'b0,1'b0,8'h41};
        vt[4]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd2,1'b0,1'b0,1'b0,8'h42};
        vt[5]  = '{1'b1,1'b1,1'b0,1'b1,8'h44, 5'd2,1'b0,1'b0,1'b0,8'h43};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd1,1'b0,1'b0,1'b0,8'h44};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd0,1'b1,1'b0,1'b0,8'h00};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd0,1'b1,1'b0,1'b0,8'h00}; // pop while empty
        vt[9]  = '{1'b1,1'b1,1'b0,1'b1,8'h50, 5'd1,1'b0,1'b0,1'b0,8'h50}; // push+pop at empty
        vt[10] = '{1'b0,1'b1,1'b0,1'b1,8'h00, 5'd0,1'b1,1'b0,1'b0,8'h00};

        bus.Tx_FIFO_Enable_i = 1'b0;
        bus.Tx_FIFO_Flush_i  = 1'b0;
        bus.Tx_FIFO_Push_i   = 1'b0;
        bus.Tx_FIFO_Pop_i    = 1'b0;
        bus.Tx_FIFO_DAT_i    = 8'h00;
        #12;
        chk("reset_state", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vt[i].push, vt[i].pop, vt[i].flush, vt[i].en, vt[i].din);
            chk($sformatf("vec%0d", i), vt[i].lvl, vt[i].emp, vt[i].ful, vt[i].ovf, vt[i].dat);
        end

        // Fill to 16, overflow, push+pop while full, then drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'(i));
            chk($sformatf("fill%0d", i), 5'(i + 1), 1'b0, (i == 15), 1'b0, 8'h00);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA);
        chk("overflow_pulse", 5'd16, 1'b0, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("overflow_clear", 5'd16, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'hBB);
        chk("pushpop_full", 5'd16, 1'b0, 1'b1, 1'b0, 8'h01);
        for (int i = 0; i < 16; i++) begin
            step(1'b1 == 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d", i), 5'(15 - i), (i == 15), 1'b0, 1'b0,
                (i == 15) ? 8'h00 : (i == 14) ? 8'hBB : 8'(i + 2));
        end

        // Advance pointers by 10, then fill 16 across the wrap point and drain.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
            chk($sformatf("adv_push%0d", i), 5'd1, 1'b0, 1'b0, 1'b0, 8'(8'h80 + i));
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            chk($sformatf("adv_pop%0d", i), 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
            chk($sformatf("wrap_fill%0d", i), 5'(i + 1), 1'b0, (i == 15), 1'b0, 8'h10);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
            chk($sformatf("wrap_drain%0d", i), 5'(15 - i), (i == 15), 1'b0, 1'b0,
                (i == 15) ? 8'h00 : 8'(8'h11 + i));
        end

        // Push+pop at level 5, then flush at level 7 with a concurrent push.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
        chk("level5", 5'd5, 1'b0, 1'b0, 1'b0, 8'h60);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h65);
        chk("pushpop_lvl5", 5'd5, 1'b0, 1'b0, 1'b0, 8'h61);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h67);
        chk("level7", 5'd7, 1'b0, 1'b0, 1'b0, 8'h61);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        chk("flush_with_push", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("flush_push_dropped", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Enable toggle at level 3 acts as flush.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h70 + i));
        chk("level3", 5'd3, 1'b0, 1'b0, 1'b0, 8'h70);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("enable_toggle_flush", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Holding-register mode: capacity 1.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        chk("hold_push", 5'd1, 1'b0, 1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
        chk("hold_overflow", 5'd1, 1'b0, 1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("hold_pop", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-burst, checked before any clock edge.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'(8'h90 + i));
        chk("pre_reset_level4", 5'd4, 1'b0, 1'b0, 1'b0, 8'h90);
        @(negedge clk);
        bus.Tx_FIFO_Push_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_reset_enable_flush", 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("post_reset_push", 5'd1, 1'b0, 1'b0, 1'b0, 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
